// File: rtl/imem_loader_if.sv
// imem_loader_if: fetch, load-stream and status signals of the instruction store.
// The master side is the core fetch stage plus program loader; the slave side is imem_loader.
// No logic here, only wiring and direction grouping.
interface imem_loader_if #(
    parameter int INSTR_W = 28,
    parameter int ADDR_W  = 16
);
    // fetch port
    logic [ADDR_W-1:0]  iAddress;
    logic               iFetch;
    logic [INSTR_W-1:0] oInstruction;
    logic               oInstrValid;
    logic               oAddrError;
    // load port
    logic               iLoadStart;
    logic [ADDR_W-1:0]  iLoadBase;
    logic [ADDR_W-1:0]  iLoadLen;
    logic [INSTR_W-1:0] iLoadData;
    logic               iLoadValid;
    logic               oLoadReady;
    logic               oLoadDone;
    logic               oBusy;
    logic [INSTR_W-1:0] oChecksum;

    modport master (
        output iAddress, iFetch, iLoadStart, iLoadBase, iLoadLen, iLoadData, iLoadValid,
        input  oInstruction, oInstrValid, oAddrError, oLoadReady, oLoadDone, oBusy, oChecksum
    );

    modport slave (
        input  iAddress, iFetch, iLoadStart, iLoadBase, iLoadLen, iLoadData, iLoadValid,
        output oInstruction, oInstrValid, oAddrError, oLoadReady, oLoadDone, oBusy, oChecksum
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: writable instruction store with a handshaked run-time program loader.
// Latency: fetch 1 cycle (registered); a gap-free N-word load pulses oLoadDone N+1 cycles after iLoadStart.
// Backpressure: oLoadReady is high only in LOAD; oBusy stalls the core in LOAD and DONE.
// Optional feature: define IMEM_CHECKSUM_EN to build the running-XOR checksum register.
module imem_loader #(
    parameter int                 INSTR_W      = 28,
    parameter int                 ADDR_W       = 16,
    parameter int                 DEPTH        = 256,
    parameter logic [INSTR_W-1:0] DEFAULT_WORD = '0
) (
    input logic          Clock,
    input logic          Reset_n,
    imem_loader_if.slave bus
);

    // Index width of the array; a single-word store still needs one index bit.
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH = 2^ADDR_W is representable in the range compare.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ADDR_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;

    // Program store; deliberately not reset so a reset mid-load keeps what was written.
    logic [INSTR_W-1:0] mem [DEPTH];

    logic               start_run;
    logic               accept;
    logic               last_word;
    logic [ADDR_W-1:0]  cnt_inc;
    logic [MEM_AW-1:0]  wr_addr;
    logic [MEM_AW-1:0]  rd_addr;
    logic               in_range;
    logic               rdy_c;
    logic               done_c;
    logic               busy_c;

    // Shared decode: load start only counts in RUN, words only in LOAD.
    always_comb begin
        start_run = (state_q == ST_RUN) && bus.iLoadStart;
        accept    = (state_q == ST_LOAD) && bus.iLoadValid;
        cnt_inc   = cnt_q + ADDR_W'(1);
        last_word = (cnt_inc == len_q);
        // Write address wraps modulo DEPTH, so long loads overwrite earlier words.
        wr_addr   = MEM_AW'(base_q + cnt_q);
        rd_addr   = MEM_AW'(bus.iAddress);
        in_range  = ({1'b0, bus.iAddress} < DEPTH_LIM);
    end

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a zero-length load skips LOAD and goes straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.iLoadStart) begin
                    state_d = (bus.iLoadLen == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && last_word) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Output decode of the load handshake and core stall.
    always_comb begin
        rdy_c  = 1'b0;
        done_c = 1'b0;
        busy_c = 1'b0;
        case (state_q)
            ST_LOAD: begin
                rdy_c  = 1'b1;
                busy_c = 1'b1;
            end
            ST_DONE: begin
                done_c = 1'b1;
                busy_c = 1'b1;
            end
            default: begin
                rdy_c  = 1'b0;
                done_c = 1'b0;
                busy_c = 1'b0;
            end
        endcase
    end

    // Load descriptor: base and length are captured on start, counter tracks accepted words.
    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        if (start_run) begin
            base_d = bus.iLoadBase;
            len_d  = bus.iLoadLen;
            cnt_d  = '0;
        end else if (accept) begin
            cnt_d  = cnt_inc;
        end
    end

    // Load descriptor registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
        end
    end

    // Array write port; only active for accepted load words.
    always_ff @(posedge Clock) begin
        if (accept) begin
            mem[wr_addr] <= bus.iLoadData;
        end
    end

    // Fetch path: start wins over a same-cycle fetch; while loading the core sees NOPs.
    always_comb begin
        instr_d = instr_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.iLoadStart) begin
                    instr_d = DEFAULT_WORD;
                end else if (bus.iFetch) begin
                    vld_d = 1'b1;
                    if (in_range) begin
                        instr_d = mem[rd_addr];
                    end else begin
                        instr_d = DEFAULT_WORD;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                instr_d = DEFAULT_WORD;
            end
        endcase
    end

    // Registered fetch result.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            instr_q <= DEFAULT_WORD;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic [INSTR_W-1:0] chk_q, chk_d;

    // Running XOR of accepted words, restarted by each load and held afterwards.
    always_comb begin
        chk_d = chk_q;
        if (start_run) begin
            chk_d = '0;
        end else if (accept) begin
            chk_d = chk_q ^ bus.iLoadData;
        end
    end

    // Checksum register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign bus.oChecksum = chk_q;
`else
    assign bus.oChecksum = '0;
`endif

    assign bus.oInstruction = instr_q;
    assign bus.oInstrValid  = vld_q;
    assign bus.oAddrError   = err_q;
    assign bus.oLoadReady   = rdy_c;
    assign bus.oLoadDone    = done_c;
    assign bus.oBusy        = busy_c;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scenario tasks for imem_loader with a fetch scoreboard and a reference store.
// Expected fetch results are queued when a fetch is driven and popped when oInstrValid returns.
// Loads are modelled word by word, including write-address wrap and checksum.
module tb_imem_loader;

    localparam logic [27:0] DEFW = 28'h0;

    typedef struct packed {
        logic [27:0] instr;
        logic        err;
    } exp_t;

    logic Clock;
    logic Reset_n;
    int   checks;
    int   errors;

    logic [27:0] ref_mem [256];
    exp_t        exp_q [$];
    logic [15:0] fetch_addrs [$];
    logic [27:0] load_words [$];
    logic [27:0] last_chk;

    imem_loader_if #(.INSTR_W(28), .ADDR_W(16)) bus ();

    imem_loader #(
        .INSTR_W(28),
        .ADDR_W(16),
        .DEPTH(256),
        .DEFAULT_WORD(28'h0)
    ) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Drive a fetch per queued address back to back, then drop iFetch and check hold.
    task automatic run_fetches(input string name);
        exp_t        e;
        logic [27:0] last;
        last = bus.oInstruction;
        for (int i = 0; i < fetch_addrs.size(); i++) begin
            bus.iFetch   = 1'b1;
            bus.iAddress = fetch_addrs[i];
            if (fetch_addrs[i] < 16'd256) begin
                e.instr = ref_mem[fetch_addrs[i][7:0]];
                e.err   = 1'b0;
            end else begin
                e.instr = DEFW;
                e.err   = 1'b1;
            end
            exp_q.push_back(e);
            last = e.instr;
            tick();
            checks++;
            if (bus.oInstrValid !== 1'b1) begin
                errors++;
                $display("FAIL %s valid[%0d]: got %b want 1", name, i, bus.oInstrValid);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (bus.oInstruction !== e.instr || bus.oAddrError !== e.err) begin
                    errors++;
                    $display("FAIL %s fetch[%0d] addr %h: got %h err %b want %h err %b", name, i,
                             fetch_addrs[i], bus.oInstruction, bus.oAddrError, e.instr, e.err);
                end
            end
        end
        bus.iFetch = 1'b0;
        tick();
        checks++;
        if (bus.oInstrValid !== 1'b0 || bus.oAddrError !== 1'b0 || bus.oInstruction !== last) begin
            errors++;
            $display("FAIL %s idle-hold: got v%b e%b %h want v0 e0 %h", name, bus.oInstrValid,
                     bus.oAddrError, bus.oInstruction, last);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s scoreboard: got %0d left want 0", name, exp_q.size());
        end
        exp_q.delete();
        fetch_addrs.delete();
    endtask

    // Run a load of load_words; iFetch stays high to show fetches are dropped.
    // gap_after/gap_len insert invalid cycles; abort_after>=0 returns with state mid-load.
    task automatic do_load(input string name, input logic [15:0] base, input logic [15:0] len,
                           input int gap_after, input int gap_len, input int exp_done,
                           input int abort_after);
        int          cyc;
        int          idx;
        int          gap_left;
        logic        drove;
        logic [27:0] chk;
        logic [27:0] exp_chk;
        chk      = '0;
        gap_left = gap_len;
        bus.iLoadBase  = base;
        bus.iLoadLen   = len;
        bus.iLoadStart = 1'b1;
        bus.iFetch     = 1'b1;
        bus.iAddress   = 16'h0010;
        tick();
        bus.iLoadStart = 1'b0;
        cyc = 1;
        idx = 0;
        while (idx < int'(len) && cyc < 300) begin
            if (idx == abort_after) return;
            checks++;
            if (bus.oLoadReady !== 1'b1 || bus.oBusy !== 1'b1 || bus.oLoadDone !== 1'b0 ||
                bus.oInstrValid !== 1'b0 || bus.oInstruction !== DEFW) begin
                errors++;
                $display("FAIL %s load-cycle %0d: got rdy%b busy%b done%b v%b %h want 1 1 0 0 %h",
                         name, cyc, bus.oLoadReady, bus.oBusy, bus.oLoadDone, bus.oInstrValid,
                         bus.oInstruction, DEFW);
            end
            if (idx == gap_after && gap_left > 0) begin
                bus.iLoadValid = 1'b0;
                bus.iLoadStart = 1'b1;      // must be ignored while loading
                bus.iLoadBase  = 16'h0080;
                gap_left--;
                drove = 1'b0;
            end else begin
                bus.iLoadValid = 1'b1;
                bus.iLoadData  = load_words[idx];
                drove = 1'b1;
            end
            tick();
            bus.iLoadStart = 1'b0;
            cyc++;
            if (drove) begin
                ref_mem[8'(base + 16'(idx))] = load_words[idx];
                chk = chk ^ load_words[idx];
                idx++;
            end
        end
        bus.iLoadValid = 1'b0;
        bus.iFetch     = 1'b0;
`ifdef IMEM_CHECKSUM_EN
        exp_chk = chk;
`else
        exp_chk = '0;
`endif
        last_chk = exp_chk;
        checks++;
        if (bus.oLoadDone !== 1'b1 || cyc != exp_done) begin
            errors++;
            $display("FAIL %s done-cycle: got done%b at cycle %0d want done1 at %0d", name,
                     bus.oLoadDone, cyc, exp_done);
        end
        checks++;
        if (bus.oBusy !== 1'b1 || bus.oLoadReady !== 1'b0 || bus.oInstrValid !== 1'b0) begin
            errors++;
            $display("FAIL %s done-state: got busy%b rdy%b v%b want 1 0 0", name, bus.oBusy,
                     bus.oLoadReady, bus.oInstrValid);
        end
        checks++;
        if (bus.oChecksum !== exp_chk) begin
            errors++;
            $display("FAIL %s checksum: got %h want %h", name, bus.oChecksum, exp_chk);
        end
        tick();
        checks++;
        if (bus.oBusy !== 1'b0 || bus.oLoadDone !== 1'b0 || bus.oLoadReady !== 1'b0) begin
            errors++;
            $display("FAIL %s back-to-run: got busy%b done%b rdy%b want 0 0 0", name, bus.oBusy,
                     bus.oLoadDone, bus.oLoadReady);
        end
        load_words.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.oInstruction !== DEFW || bus.oInstrValid !== 1'b0 || bus.oAddrError !== 1'b0 ||
            bus.oLoadReady !== 1'b0 || bus.oLoadDone !== 1'b0 || bus.oBusy !== 1'b0 ||
            bus.oChecksum !== 28'h0) begin
            errors++;
            $display("FAIL %s: got instr %h v%b e%b rdy%b done%b busy%b chk %h want all zero",
                     name, bus.oInstruction, bus.oInstrValid, bus.oAddrError, bus.oLoadReady,
                     bus.oLoadDone, bus.oBusy, bus.oChecksum);
        end
    endtask

    task automatic test_reset();
        check_reset_outputs("reset_values");
    endtask

    task automatic test_basic_load();
        load_words = '{28'h0000011, 28'h0000012, 28'h0000013, 28'h0000014};
        do_load("basic", 16'h0010, 16'd4, -1, 0, 5, -1);
        // Fetch issued in cycle N+2 directly after the load, back to back.
        fetch_addrs = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
        run_fetches("basic_fetch");
    endtask

    task automatic test_backpressure();
        load_words = '{28'h5A5A5A5};
        do_load("sentinel", 16'h0014, 16'd1, -1, 0, 2, -1);
        load_words = '{28'h0000021, 28'h0000022, 28'h0000023, 28'h0000024};
        do_load("backpressure", 16'h0010, 16'd4, 2, 3, 8, -1);
        fetch_addrs = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014};
        run_fetches("bp_fetch");
    endtask

    task automatic test_boundaries();
        fetch_addrs = '{16'h0100, 16'h0010, 16'hFFFF, 16'h00FF};
        // 0xFF is overwritten below; load something known first.
        load_words = '{28'h0BADBAD};
        do_load("pre_ff", 16'h00FF, 16'd1, -1, 0, 2, -1);
        run_fetches("range");
        load_words = '{28'hABCDEF1, 28'h1234567};
        do_load("wrap", 16'h00FF, 16'd2, -1, 0, 3, -1);
        fetch_addrs = '{16'h00FF, 16'h0000};
        run_fetches("wrap_fetch");
        load_words.delete();
        do_load("len_zero", 16'h0020, 16'd0, -1, 0, 1, -1);
    endtask

    task automatic test_reset_mid_load();
        load_words = '{28'h00000A0, 28'h00000A1, 28'h00000A2, 28'h00000A3};
        do_load("old_data", 16'h0040, 16'd4, -1, 0, 5, -1);
        load_words = '{28'h00000B0, 28'h00000B1, 28'h00000B2, 28'h00000B3};
        do_load("abort", 16'h0040, 16'd4, -1, 0, 0, 2);
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_load");
        bus.iLoadValid = 1'b0;
        bus.iFetch     = 1'b0;
        load_words.delete();
        #1;
        Reset_n = 1'b1;
        tick();
        checks++;
        if (bus.oBusy !== 1'b0 || bus.oLoadReady !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got busy%b rdy%b want 0 0", bus.oBusy, bus.oLoadReady);
        end
        fetch_addrs = '{16'h0040, 16'h0041, 16'h0042, 16'h0043};
        run_fetches("abort_fetch");
    endtask

    task automatic test_reset_mid_fetch();
        bus.iFetch   = 1'b1;
        bus.iAddress = 16'h0010;
        tick();
        checks++;
        if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== ref_mem[8'h10]) begin
            errors++;
            $display("FAIL pre_reset_fetch: got v%b %h want v1 %h", bus.oInstrValid,
                     bus.oInstruction, ref_mem[8'h10]);
        end
        bus.iAddress   = 16'($urandom);
        bus.iLoadData  = 28'($urandom);
        bus.iLoadValid = 1'($urandom);
        bus.iLoadBase  = 16'($urandom);
        bus.iLoadLen   = 16'($urandom);
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        check_reset_outputs("reset_held");
        bus.iFetch     = 1'b0;
        bus.iLoadValid = 1'b0;
        #2;
        Reset_n = 1'b1;
        tick();
        fetch_addrs = '{16'h0011, 16'h0100, 16'h0012};
        run_fetches("post_reset_fetch");
    endtask

    task automatic test_checksum();
        load_words = '{28'h0000001, 28'h0000002, 28'h0000004};
        do_load("checksum", 16'h0030, 16'd3, -1, 0, 4, -1);
        fetch_addrs = '{16'h0030, 16'h0031, 16'h0032};
        run_fetches("chk_fetch");
        checks++;
`ifdef IMEM_CHECKSUM_EN
        if (bus.oChecksum !== 28'h0000007) begin
            errors++;
            $display("FAIL checksum_hold: got %h want 0000007", bus.oChecksum);
        end
`else
        if (bus.oChecksum !== 28'h0000000) begin
            errors++;
            $display("FAIL checksum_off: got %h want 0000000", bus.oChecksum);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_chk = '0;
        Reset_n        = 1'b0;
        bus.iAddress   = '0;
        bus.iFetch     = 1'b0;
        bus.iLoadStart = 1'b0;
        bus.iLoadBase  = '0;
        bus.iLoadLen   = '0;
        bus.iLoadData  = '0;
        bus.iLoadValid = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 'x;
        #12;
        test_reset();
        Reset_n = 1'b1;
        tick();
        test_basic_load();
        test_backpressure();
        test_boundaries();
        test_reset_mid_load();
        test_reset_mid_fetch();
        test_checksum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction memory for the MiniAlu-class core. It replaces the hard-coded case-statement program store with a writable array, so programs are downloaded at run time instead of being recompiled. It sits between the core's fetch stage and a word-wide program loader, such as a UART or test-bench driver. Fetches use a registered, one-cycle read. A handshaked loader state machine writes the array and stalls the core while loading.

## Interface
- INSTR_W, 28: instruction width; matches the {opcode, dest, src1, src0} format.
- ADDR_W, 16: width of the address and length ports.
- DEPTH, 256: number of words; must be a power of two, at most 2^ADDR_W.
- DEFAULT_WORD, 28'h0: word returned for out-of-range or suppressed fetches (the NOP encoding).
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- iAddress  in  ADDR_W  fetch address.
- iFetch  in  1  fetch strobe.
- oInstruction  out  INSTR_W  registered fetched word.
- oInstrValid  out  1  oInstruction holds the result of a fetch issued in the previous cycle.
- oAddrError  out  1  the previous fetch was out of range; asserted together with oInstrValid.
- iLoadStart  in  1  single-cycle request to start a load.
- iLoadBase  in  ADDR_W  first write address; captured on iLoadStart.
- iLoadLen  in  ADDR_W  number of words to write; captured on iLoadStart.
- iLoadData  in  INSTR_W  load word.
- iLoadValid  in  1  iLoadData is valid.
- oLoadReady  out  1  the block accepts a load word this cycle.
- oLoadDone  out  1  single-cycle pulse at the end of a load.
- oBusy  out  1  the core must stall; high in LOAD and DONE.
- oChecksum  out  INSTR_W  XOR of all words accepted in the last load (see Configuration).

## Operation
- Reset values: oInstruction=DEFAULT_WORD; oInstrValid, oAddrError, oLoadReady, oLoadDone and oBusy all 0; oChecksum=0; state RUN; word counter 0.
- Array contents are not reset. A reset mid-load keeps every word written so far.
- RUN state:
  - iFetch=1 with iAddress<DEPTH: next cycle oInstruction=mem[iAddress], oInstrValid=1.
  - iFetch=1 with iAddress≥DEPTH: next cycle oInstruction=DEFAULT_WORD, oInstrValid=1, oAddrError=1.
  - iFetch=0: oInstrValid=0 next cycle; oInstruction holds its value.
- iLoadStart in RUN: capture base and length, clear the counter and checksum, then go to LOAD. If iLoadLen=0, go straight to DONE.
  - iLoadStart has priority over a same-cycle iFetch. That fetch is dropped and oInstrValid=0 next cycle.
- LOAD state:
  - oLoadReady=1 and oBusy=1.
  - Fetches are ignored: oInstrValid=0 and oInstruction=DEFAULT_WORD.
  - A word is accepted when iLoadValid and oLoadReady are both 1. It is written to mem[(base+count) mod DEPTH], and the counter increments.
  - Gaps in iLoadValid are allowed. Lengths above DEPTH wrap and overwrite earlier words.
  - iLoadStart is ignored in LOAD.
  - When the accepted word is number iLoadLen, go to DONE.
- DONE state (one cycle): oLoadDone=1, oBusy=1, oLoadReady=0; then go to RUN.
- Widths: the counter is ADDR_W bits. The write address is the low log2(DEPTH) bits of base+count.

## Timing
- Fetch latency is 1 cycle. Back-to-back fetches give one valid word per cycle.
- Load sequence, with iLoadStart in cycle 0:
  - oLoadReady=1 from cycle 1.
  - With no gaps, words are accepted in cycles 1..N.
  - oLoadDone=1 in cycle N+1.
  - RUN in cycle N+2; a fetch issued in N+2 returns new data in N+3.
- When iLoadLen=0, oLoadDone=1 in cycle 1 and the state is RUN in cycle 2.
- Reset_n assertion is asynchronous and forces all outputs to their reset values immediately. Deassertion is sampled on the next Clock edge.

## Configuration
- IMEM_CHECKSUM_EN defined: oChecksum is a running XOR of accepted words. It is cleared on iLoadStart, is final when oLoadDone=1, and holds its value until the next iLoadStart.
- IMEM_CHECKSUM_EN undefined: oChecksum is tied to 0 and no checksum register is built.

## Test plan
- Reset: drive Reset_n=0 mid-fetch with random inputs → all outputs take their reset values in the same cycle; after release, the first fetch behaves normally.
- Basic load: base=0x10, len=4, words 0x0000011..0x0000014 with no gaps → oLoadDone in cycle 5; fetching 0x10..0x13 returns the words in order with 1-cycle latency.
- Backpressure: same load with iLoadValid low for 3 cycles after word 2 → exactly 4 writes; oLoadDone 3 cycles later than in the basic load; oBusy high throughout.
- Boundaries:
  - Fetch 0x0100 with DEPTH=256 → DEFAULT_WORD with oAddrError=1 for one cycle.
  - Load with base=0xFF, len=2 → writes land at 0xFF and 0x00.
- Reset mid-load: after 2 of 4 words → state RUN, oBusy=0; base+0 and base+1 hold new data, base+2 holds old data.
- Checksum: with IMEM_CHECKSUM_EN, load 0x0000001, 0x0000002, 0x0000004 → oChecksum=0x0000007 when oLoadDone=1. Without the macro → oChecksum stays 0.
